// File: rtl/aes_ctr_ctrl.sv
// CTR-mode sequencer around aes_core: counter block out, keystream back, XOR with the data stream.
// Per-block latency: LOAD (1) + core latency + XOR (>=1, waits din_valid) + OUT (>=1, waits dout_ready).
// Backpressure: din_ready only while a keystream block is held; dout holds stable until dout_ready.
module aes_ctr_ctrl #(
  parameter int CTR_WIDTH = 32,
  parameter int NB_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          aes_len,
  input  logic [255:0]        key,
  input  logic [127:0]        iv,
  input  logic [NB_WIDTH-1:0] num_blocks,
  output logic                busy,
  output logic                done,
  input  logic [127:0]        din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [127:0]        dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                core_rst,
  output logic                core_enc,
  output logic [1:0]          core_aes_len,
  output logic [255:0]        core_key,
  output logic [127:0]        core_block,
  input  logic [127:0]        core_out,
  input  logic                core_valid
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_XOR, S_OUT} state_t;

  state_t              state_q, state_d;
  logic                done_q, done_d;
  logic                dout_valid_q;
  logic [127:0]        ctr_q;
  logic [127:0]        ks_q;
  logic [127:0]        dout_q;
  logic [255:0]        key_q;
  logic [1:0]          len_q;
  logic [NB_WIDTH-1:0] rem_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_blocks != '0) state_d = S_LOAD;
          else                  done_d  = 1'b1;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (core_valid) state_d = S_XOR;
      S_XOR:  if (din_valid) state_d = S_OUT;
      S_OUT: begin
        if (dout_ready) begin
          if (rem_q == NB_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      ctr_q        <= '0;
      ks_q         <= '0;
      dout_q       <= '0;
      key_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == S_IDLE && start && num_blocks != '0) begin
        key_q <= key;
        len_q <= aes_len;
        ctr_q <= iv;
        rem_q <= num_blocks;
      end
      if (state_q == S_RUN && core_valid) ks_q <= core_out;
      if (state_q == S_XOR && din_valid) begin
        dout_q       <= din ^ ks_q;
        dout_valid_q <= 1'b1;
      end
      // Counter advances only once the block has left, so a stalled sink never skips a counter value.
      if (state_q == S_OUT && dout_ready) begin
        dout_valid_q            <= 1'b0;
        rem_q                   <= rem_q - NB_WIDTH'(1);
        ctr_q[CTR_WIDTH-1:0]    <= ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign din_ready    = (state_q == S_XOR);
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign core_rst     = (state_q != S_RUN);
  assign core_enc     = 1'b1;
  assign core_aes_len = len_q;
  assign core_key     = key_q;
  assign core_block   = ctr_q;

endmodule

// File: doc/aes_ctr_ctrl.md
Name: aes_ctr_ctrl

Overview:
- CTR-mode sequencer directly upstream of aes_core; also consumes aes_core's output.
- Latches key, key length, IV and block count on start.
- For each block: presents counter block to aes_core, restarts the core, captures the keystream, and XORs it with one 128-bit input data block under valid/ready handshakes.
- Serves as the bulk encrypt/decrypt engine of the SE; CTR encrypt and decrypt are the same operation.

Parameters:
- CTR_WIDTH, 32: number of IV low bits incremented per block, mod 2^CTR_WIDTH; the upper 128-CTR_WIDTH bits are never modified.
- NB_WIDTH, 16: width of the block-count input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle launch pulse; sampled only in IDLE.
- aes_len  in  2  01=AES-128, 10=AES-192, 11=AES-256; latched on start.
- key  in  256  key, MSB-aligned (AES-128 uses [255:128]); latched on start.
- iv  in  128  initial counter block; latched on start.
- num_blocks  in  NB_WIDTH  number of blocks to process; latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- din  in  128  input data block.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle.
- dout  out  128  din XOR keystream.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  sink accepts dout.
- core_rst  out  1  active-high reset/restart to aes_core.
- core_enc  out  1  tied to 1 (encrypt).
- core_aes_len  out  2  latched aes_len.
- core_key  out  256  latched key.
- core_block  out  128  current counter block (aes_core plaintext).
- core_out  in  128  aes_core ciphertext.
- core_valid  in  1  aes_core valid.

Behaviour:
- Reset values (async, rst=0): FSM in IDLE; busy=0, done=0, din_ready=0, dout_valid=0, dout=0, core_rst=1, core_block=0, core_key=0, core_aes_len=0, internal ks=0, remaining=0.
- IDLE:
  - core_rst=1.
  - On start with num_blocks!=0: latch all inputs; ctr<=iv; remaining<=num_blocks; go to LOAD.
  - On start with num_blocks==0: done=1 on the next cycle, stay in IDLE, busy stays 0, no core activity.
  - start is ignored in every other state.
- LOAD (exactly 1 cycle):
  - core_rst=1, core_block=ctr.
  - Next state RUN.
- RUN:
  - core_rst=0; core_block, core_key and core_aes_len held stable.
  - On core_valid: ks<=core_out; go to XOR.
  - core_valid outside RUN is ignored.
- XOR:
  - din_ready=1.
  - On din_valid: dout<=din^ks; dout_valid<=1; din_ready drops next cycle; go to OUT.
  - core_rst=1 from XOR onward, so the core idles.
- OUT:
  - dout_valid=1; dout held stable until dout_ready.
  - On dout_ready: dout_valid<=0; remaining<=remaining-1; ctr low CTR_WIDTH bits <= +1 (wrap to 0, upper bits unchanged).
  - Then: if remaining==1, done=1 for one cycle and go to IDLE (busy<=0); else go to LOAD.
- Handshake rules:
  - A transfer occurs only when valid and ready are both high at a rising edge.
  - din_ready is never high outside XOR.
  - dout_valid never deasserts without dout_ready.
- Minimum per-block latency: 1 (LOAD) + core latency + 1 (XOR, din present) + 1 (OUT, dout_ready high).
- Reset mid-operation: immediate return to IDLE with all reset values.
  - Partially produced output is discarded.
  - core_rst=1 holds the core idle.
  - No done pulse.
- Changes to key/iv/aes_len/num_blocks inputs while busy have no effect.

Test Plan:
1. AES-256 key 000102…1f, iv 00112233445566778899aabbccddeeff, num_blocks=1, din=0 -> dout=8ea2b7ca516745bfeafc49904b496089, then done pulse; busy low the cycle after done.
2. AES-128 key 000102…0f and AES-192 key 000102…17, same iv/din -> dout=69c4e0d86a7b0430d8cdb78070b4c55a and dda97ca4864cdfe06eaf70a0ec0d7191 respectively.
3. Counter wrap: iv low word ffffffff, num_blocks=3 -> core_block low 32 bits = ffffffff, 00000000, 00000001; upper 96 bits unchanged; 3 dout transfers, 1 done.
4. Backpressure: din_valid withheld 4 cycles, then dout_ready low 6 cycles -> no din_ready outside XOR; dout/dout_valid stable; ctr not advanced until dout_ready; din_ready drops the cycle after acceptance.
5. num_blocks=0 start -> done high exactly 1 cycle, core_rst stays 1, busy stays 0; start pulsed while busy is ignored.
6. rst low during RUN of block 2 of 4 -> all outputs at reset values asynchronously, no done; a new job started after reset produces a correct case-1 result.
